bcd_serial_alu: RTL and testbench
=================================

# bcd_serial_alu

Parametrised, sequential BCD add/subtract unit processing one decimal digit per clock, least-significant digit first. It generalises the four-digit combinational BCD adder/subtractor to `DIGITS` digits and adds behaviour the combinational version lacks:

- a start/busy/done handshake;
- true signed subtraction results: magnitude plus a `negative` flag, produced by a serial ten's-complement fix-up pass;
- optional input-digit validation.

It sits between the operand registers and the display/result path of the BCD datapath.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; must be ≥ 1.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: reset, asynchronous assert, active low.
- `start`  input  1: request a new operation; sampled only when accepted.
- `op`  input  1: 0 = add (A+B), 1 = subtract (A−B).
- `bcd_a`  input  4*DIGITS: operand A, digit i at bits [4i+3:4i].
- `bcd_b`  input  4*DIGITS: operand B, same packing.
- `busy`  output  1: high while an operation is in progress.
- `done`  output  1: one-cycle pulse when results become valid.
- `result`  output  4*DIGITS: BCD sum, or magnitude of the difference.
- `carry_out`  output  1: add only; decimal overflow beyond `DIGITS` digits.
- `negative`  output  1: subtract only; high when A < B.
- `invalid`  output  1: any input digit > 9. Present only with `BCD_SERIAL_ALU_CHECK_EN`; otherwise tied 0.

## Operation
- **States:** IDLE, ADD, FIX, DONE.
- **Acceptance:** `start` is accepted in IDLE or DONE. On acceptance:
  - latch `bcd_a`, `bcd_b` and `op`;
  - for subtract, replace each B digit with its nine's complement (9−d);
  - set the digit counter to 0 and the carry to `op`;
  - go to ADD.
- **ADD:** each cycle, digit i computes s = a_i + b'_i + c. The range is 0..19, so a 5-bit intermediate is used.
  - If s > 9: digit = s−10, c = 1. Otherwise: digit = s, c = 0.
  - The digit is written into the result shift register and the counter increments.
  - After digit `DIGITS`−1 completes, the next state is chosen:
    - add: `carry_out` = c, go to DONE;
    - subtract with c = 1: result is non-negative, `negative` = 0, go to DONE;
    - subtract with c = 0: `negative` = 1, go to FIX.
- **FIX:** replaces the raw result R with its ten's complement, 10^DIGITS − R, one digit per cycle LSD first. Each digit becomes (9 − r_i) + c, with c starting at 1 and the same >9 correction as ADD. FIX lasts `DIGITS` cycles, then goes to DONE.
- **DONE:** `done` = 1 for exactly one cycle. Next state is ADD if `start` is high that cycle (back-to-back operation), otherwise IDLE.
- **Output holding:** `result`, `carry_out`, `negative` and `invalid` hold their values from DONE until the next accepted `start`. They clear to 0 on acceptance.
- **Ignored inputs:** `start` is ignored in ADD and FIX. Operand input changes after acceptance have no effect.
- **Zero difference:** A == B on subtract yields result 0, `negative` = 0, and no FIX pass.
- **Reset:** asserting `rst_n` low at any time, including mid-operation, immediately forces IDLE. All outputs, the counter and the carry go to 0. No `done` is produced for the aborted operation.

## Timing
- **Accept cycle:** the cycle in which `start` is accepted is T0. `busy` rises at T0+1.
- **Add, or subtract with A ≥ B:** ADD covers T0+1 .. T0+DIGITS. `done` is high at T0+DIGITS+1.
- **Subtract with A < B:** FIX covers T0+DIGITS+1 .. T0+2·DIGITS. `done` is high at T0+2·DIGITS+1.
- **`busy`:** high in ADD and FIX only; low in IDLE and DONE.
- **Result validity:** results are valid in the same cycle `done` is high.
- **Throughput:** back-to-back, one operation per DIGITS+1 cycles when no FIX pass is needed.
- **Reset values:** `busy` = 0, `done` = 0, `result` = 0, `carry_out` = 0, `negative` = 0, `invalid` = 0.

## Configuration
- **`BCD_SERIAL_ALU_CHECK_EN` defined:**
  - at acceptance, every digit of both operands is checked;
  - if any digit is > 9, the operation goes directly to DONE on the next cycle;
  - DONE then shows `invalid` = 1, `result` = 0, `carry_out` = 0, `negative` = 0;
  - `busy` never rises for that operation.
- **Not defined:**
  - no checking; the `invalid` port remains but is tied 0;
  - illegal digits are processed through the normal arithmetic, and the result is undefined but deterministic.

## Test plan
All scenarios use DIGITS = 4.
- **Add with inner carries:** 0999 + 0001 → `result` 1000, `carry_out` 0, `negative` 0, `done` at T0+5.
- **Add overflow:** 9999 + 0001 → `result` 0000, `carry_out` 1, `done` at T0+5.
- **Subtract, A ≥ B:** 0500 − 0200 → `result` 0300, `negative` 0, `done` at T0+5. Also 1234 − 1234 → 0000, `negative` 0, `done` at T0+5.
- **Subtract, A < B:** 0200 − 0500 → `result` 0300, `negative` 1, `done` at T0+9, `busy` high for 8 cycles.
- **Handshake:**
  - `start` pulsed again during ADD → ignored, the first result is unchanged;
  - `start` held through DONE → second operation accepted with no IDLE cycle in between;
  - `rst_n` low at T0+2 → all outputs 0 and no `done` pulse.
- **Validation (`BCD_SERIAL_ALU_CHECK_EN` defined):** A = 00A0, B = 0001 → `invalid` 1, `result` 0000, `done` at T0+1, `busy` never high.

Source files
------------

// File: rtl/bcd_serial_alu.sv
// Serial BCD add/subtract, one decimal digit per clock, LSD first, with a ten's-complement
// fix-up pass for negative differences. Define BCD_SERIAL_ALU_CHECK_EN to enable input-digit validation.
module bcd_serial_alu #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] bcd_a,
  input  logic [4*DIGITS-1:0] bcd_b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                negative,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       a_q, b_q, res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q, c_q, carry_q, neg_q;
  logic               accept, last_digit, bad_in;
  logic [4:0]         sum_add, sum_fix;

  // One decimal digit step: {carry, digit}, with the >9 decimal correction.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

`ifdef BCD_SERIAL_ALU_CHECK_EN
  function automatic logic any_invalid(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  logic inv_q;
  assign bad_in  = any_invalid(bcd_a, bcd_b);
  assign invalid = inv_q;
`else
  assign bad_in  = 1'b0;
  assign invalid = 1'b0;
`endif

  assign accept     = start && (state == S_IDLE || state == S_DONE);
  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));
  assign sum_add    = digit_add(a_q[3:0], b_q[3:0], c_q);
  assign sum_fix    = digit_add(4'd9 - res_q[3:0], 4'd0, c_q);

  assign busy      = (state == S_ADD) || (state == S_FIX);
  assign done      = (state == S_DONE);
  assign result    = res_q;
  assign carry_out = carry_q;
  assign negative  = neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = bad_in ? S_DONE : S_ADD;
      S_ADD:
        if (last_digit) state_nxt = (!op_q || sum_add[4]) ? S_DONE : S_FIX;
      S_FIX:  if (last_digit) state_nxt = S_DONE;
      S_DONE:
        if (start) state_nxt = bad_in ? S_DONE : S_ADD;
        else       state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Digit datapath: operands shift right one digit per ADD cycle, result shifts in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
`ifdef BCD_SERIAL_ALU_CHECK_EN
      inv_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= bcd_a;
      b_q     <= op ? nines(bcd_b) : bcd_b;
      op_q    <= op;
      c_q     <= op;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
`ifdef BCD_SERIAL_ALU_CHECK_EN
      inv_q   <= bad_in;
`endif
    end else begin
      case (state)
        S_ADD: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          res_q <= W'({sum_add[3:0], res_q} >> 4);
          c_q   <= sum_add[4];
          if (last_digit) begin
            cnt_q <= '0;
            if (!op_q) begin
              carry_q <= sum_add[4];
            end else if (!sum_add[4]) begin
              // No end-around carry: A < B, so the raw result needs ten's complementing.
              neg_q <= 1'b1;
              c_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIX: begin
          res_q <= W'({sum_fix[3:0], res_q} >> 4);
          c_q   <= sum_fix[4];
          cnt_q <= last_digit ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Randomized and directed bench for bcd_serial_alu (DIGITS = 4) against an integer-arithmetic model.
module tb_bcd_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] bcd_a = '0;
  logic [15:0] bcd_b = '0;
  logic        busy, done, carry_out, negative, invalid;
  logic [15:0] result;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_serial_alu #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .bcd_a(bcd_a), .bcd_b(bcd_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .negative(negative), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int m;
    m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic o,
                       output logic [15:0] res, output logic c, output logic n,
                       output int done_at);
    int av, bv;
    av = bcd2int(a);
    bv = bcd2int(b);
    c = 1'b0;
    n = 1'b0;
    done_at = 5;
    if (!o) begin
      res = int2bcd((av + bv) % 10000);
      c   = (av + bv) >= 10000;
    end else if (av >= bv) begin
      res = int2bcd(av - bv);
    end else begin
      res = int2bcd(bv - av);
      n = 1'b1;
      done_at = 9;
    end
  endtask

  // Launch one operation; inputs are scrambled after acceptance, optional start pulse at pulse_k.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                        input int pulse_k, input string tag);
    logic [15:0] exp_res;
    logic        exp_c, exp_n;
    int          exp_done, busy_n, done_k;
    model(a, b, o, exp_res, exp_c, exp_n, exp_done);
    @(negedge clk);
    bcd_a = a; bcd_b = b; op = o; start = 1'b1;
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 30 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        bcd_a = 16'($urandom);
        bcd_b = 16'($urandom);
        op    = ~o;
      end
      if (k == pulse_k)     start = 1'b1;
      if (k == pulse_k + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_k = k;
        check({tag, "/result"},  32'(result),    32'(exp_res));
        check({tag, "/carry"},   32'(carry_out), 32'(exp_c));
        check({tag, "/neg"},     32'(negative),  32'(exp_n));
        check({tag, "/invalid"}, 32'(invalid),   32'(0));
      end
    end
    check({tag, "/done_cycle"}, 32'(done_k), 32'(exp_done));
    check({tag, "/busy_cycles"}, 32'(busy_n), 32'(exp_done - 1));
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'(0));
    check({tag, "/hold"},       32'(result), 32'(exp_res));
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          done_cnt;

    #12;
    check("reset/busy",   32'(busy),      32'(0));
    check("reset/done",   32'(done),      32'(0));
    check("reset/result", 32'(result),    32'(0));
    check("reset/flags",  32'({carry_out, negative, invalid}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0999, 16'h0001, 1'b0, 0, "add_carries");
    run_op(16'h9999, 16'h0001, 1'b0, 0, "add_overflow");
    run_op(16'h0500, 16'h0200, 1'b1, 0, "sub_pos");
    run_op(16'h1234, 16'h1234, 1'b1, 0, "sub_zero");
    run_op(16'h0200, 16'h0500, 1'b1, 0, "sub_neg");
    run_op(16'h0000, 16'h0001, 1'b1, 0, "sub_neg_small");
    run_op(16'h4321, 16'h1111, 1'b0, 2, "start_ignored");

    for (int t = 0; t < 30; t++) begin
      ra = int2bcd(int'($urandom_range(0, 9999)));
      rb = (t % 7 == 0) ? ra : int2bcd(int'($urandom_range(0, 9999)));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", t));
    end

    // Back-to-back: start held high from launch through the first DONE.
    @(negedge clk);
    bcd_a = 16'h0123; bcd_b = 16'h0456; op = 1'b0; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin bcd_a = 16'h0300; bcd_b = 16'h0100; op = 1'b1; end
      if (k == 5) begin
        check("b2b/done1",   32'(done),   32'(1));
        check("b2b/result1", 32'(result), 32'h0579);
      end
      if (k == 6) begin
        check("b2b/no_idle", 32'(busy), 32'(1));
        start = 1'b0;
      end
      if (k == 10) begin
        check("b2b/done2",   32'(done),     32'(1));
        check("b2b/result2", 32'(result),   32'h0200);
        check("b2b/neg2",    32'(negative), 32'(0));
      end
    end
    @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    bcd_a = 16'h0999; bcd_b = 16'h0001; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/busy",   32'(busy),   32'(0));
    check("abort/done",   32'(done),   32'(0));
    check("abort/result", 32'(result), 32'(0));
    check("abort/flags",  32'({carry_out, negative, invalid}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort/no_done", 32'(done_cnt), 32'(0));

`ifdef BCD_SERIAL_ALU_CHECK_EN
    @(negedge clk);
    bcd_a = 16'h00A0; bcd_b = 16'h0001; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("inv/done",    32'(done),    32'(1));
    check("inv/busy",    32'(busy),    32'(0));
    check("inv/invalid", 32'(invalid), 32'(1));
    check("inv/result",  32'(result),  32'(0));
    @(negedge clk);
    check("inv/hold", 32'(invalid), 32'(1));
    run_op(16'h0042, 16'h0058, 1'b0, 0, "inv_recover");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
